// File: rtl/except_ctrl_pkg.sv
// Shared constants for the MEM-stage exception controller: exception codes,
// cp0 register numbers, Status bit positions, FSM states and the flag layout.
package except_ctrl_pkg;

  // Exception codes presented to cp0 (0 = no exception)
  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'hA;
  localparam logic [31:0] EXC_OVF  = 32'hC;
  localparam logic [31:0] EXC_TR   = 32'hD;
  localparam logic [31:0] EXC_ERET = 32'hE;

  // Default general exception entry
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  // cp0 register numbers
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  // Status bit positions
  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;

  // Controller states (kept as plain constants so the encoding is fixed)
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Per-instruction exception flags, MSB first as they arrive on mem_exc_i
  typedef struct packed {
    logic adel_if;
    logic ri;
    logic ovf;
    logic trap;
    logic sys;
    logic brk;
    logic adel_ls;
    logic ades;
    logic eret;
  } exc_flags_t;

  // Interrupt request: any unmasked pending line, global enable on, not at EXL
  function automatic logic int_request(input logic [31:0] status,
                                       input logic [31:0] cause);
    return (|(status[15:8] & cause[15:8])) & status[STATUS_IE_BIT]
           & ~status[STATUS_EXL_BIT];
  endfunction

endpackage

// File: rtl/except_ctrl_bypass.sv
// cp0_bypass: forwards an in-flight WB-stage mtc0 onto the Status/Cause/EPC
// values seen by the exception controller, so decisions use current state.
module cp0_bypass
  import except_ctrl_pkg::*;
#(
  parameter logic [4:0] STATUS_ADDR = CP0_REG_STATUS,
  parameter logic [4:0] CAUSE_ADDR  = CP0_REG_CAUSE,
  parameter logic [4:0] EPC_ADDR    = CP0_REG_EPC
) (
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_data,
  output logic [31:0] status_eff,
  output logic [31:0] cause_eff,
  output logic [31:0] epc_eff
);

  logic hit_status;
  logic hit_cause;
  logic hit_epc;

  assign hit_status = wb_we && (wb_waddr == STATUS_ADDR);
  assign hit_cause  = wb_we && (wb_waddr == CAUSE_ADDR);
  assign hit_epc    = wb_we && (wb_waddr == EPC_ADDR);

  // Forward the pending write; only the software-interrupt bits of Cause
  // are writable by mtc0, so the rest always comes from cp0.
  always_comb begin
    status_eff = hit_status ? wb_data : cp0_status;
    cause_eff  = cp0_cause;
    if (hit_cause) cause_eff[9:8] = wb_data[9:8];
    epc_eff    = hit_epc ? wb_data : cp0_epc;
  end

endmodule

// File: rtl/except_ctrl.sv
// except_ctrl: MEM-stage exception/interrupt controller. Prioritises the
// instruction's exception flags and pending interrupts into one cp0 code,
// then spends one FLUSH cycle redirecting the PC to the vector or EPC.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR      = EXC_VECTOR_DEFAULT,
  parameter logic [4:0]  CP0_STATUS_ADDR = CP0_REG_STATUS,
  parameter logic [4:0]  CP0_CAUSE_ADDR  = CP0_REG_CAUSE,
  parameter logic [4:0]  CP0_EPC_ADDR    = CP0_REG_EPC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [8:0]  mem_exc_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  logic [31:0] status_eff;
  logic [31:0] cause_eff;
  logic [31:0] epc_eff;
  logic        int_req;
  logic        int_pend_q;
  logic [0:0]  state_q;
  logic [31:0] target_q;
  logic        take;
  exc_flags_t  exc;
  logic [31:0] code;
  logic [31:0] bad;

  cp0_bypass #(
    .STATUS_ADDR (CP0_STATUS_ADDR),
    .CAUSE_ADDR  (CP0_CAUSE_ADDR),
    .EPC_ADDR    (CP0_EPC_ADDR)
  ) u_bypass (
    .cp0_status (cp0_status_i),
    .cp0_cause  (cp0_cause_i),
    .cp0_epc    (cp0_epc_i),
    .wb_we      (wb_cp0_we_i),
    .wb_waddr   (wb_cp0_waddr_i),
    .wb_data    (wb_cp0_data_i),
    .status_eff (status_eff),
    .cause_eff  (cause_eff),
    .epc_eff    (epc_eff)
  );

  assign int_req = int_request(status_eff, cause_eff);
  assign exc     = exc_flags_t'(mem_exc_i);

  // Only a real, unstalled instruction in RUN can commit an exception;
  // reset also suppresses it so every output reads zero while held.
  assign take = (state_q == ST_RUN) && mem_valid_i && !stall_i && !rst;

  // Fixed-priority encoder; interrupts outrank anything the instruction did
  always_comb begin
    code = EXC_NONE;
    bad  = 32'h0;
    if (take) begin
      if (int_pend_q) begin
        code = EXC_INT;
      end else if (exc.adel_if) begin
        code = EXC_ADEL;
        bad  = mem_pc_i;
      end else if (exc.ri) begin
        code = EXC_RI;
      end else if (exc.ovf) begin
        code = EXC_OVF;
      end else if (exc.trap) begin
        code = EXC_TR;
      end else if (exc.sys) begin
        code = EXC_SYS;
      end else if (exc.brk) begin
        code = EXC_BP;
      end else if (exc.adel_ls) begin
        code = EXC_ADEL;
        bad  = mem_addr_i;
      end else if (exc.ades) begin
        code = EXC_ADES;
        bad  = mem_addr_i;
      end else if (exc.eret) begin
        code = EXC_ERET;
      end
    end
  end

  assign excepttype_o        = code;
  assign bad_addr_o          = bad;
  assign current_inst_addr_o = mem_pc_i;
  assign is_in_delayslot_o   = mem_in_delayslot_i;
  assign flush_o             = (state_q == ST_FLUSH);
  assign new_pc_o            = flush_o ? target_q : 32'h0;

  // Interrupt sampling and the RUN/FLUSH sequencer; the redirect target is
  // captured in the excepting cycle so a same-cycle mtc0 EPC is honoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      int_pend_q <= 1'b0;
      target_q   <= 32'h0;
    end else begin
      int_pend_q <= int_req;
      case (state_q)
        ST_RUN: begin
          if (code != EXC_NONE) begin
            state_q  <= ST_FLUSH;
            target_q <= (code == EXC_ERET) ? epc_eff : EXC_VECTOR;
          end
        end
        default: begin
          state_q  <= ST_RUN;
          target_q <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_except_ctrl.sv
// Bench for except_ctrl: directed scenarios plus a randomized run checked
// against a cycle-level reference model built from the priority rules.
module tb_except_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [8:0]  mem_exc_i;
  logic [31:0] mem_addr_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  int checks = 0;
  int errors = 0;

  // Code for each flag bit of mem_exc_i (index = bit number)
  logic [31:0] code_of_bit [9] = '{32'hE, 32'h5, 32'h4, 32'h9, 32'h8,
                                   32'hD, 32'hC, 32'hA, 32'h4};

  except_ctrl dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .mem_valid_i(mem_valid_i),
    .mem_pc_i(mem_pc_i), .mem_in_delayslot_i(mem_in_delayslot_i),
    .mem_exc_i(mem_exc_i), .mem_addr_i(mem_addr_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i),
    .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_code(input bit ip, input logic [8:0] e);
    if (ip) return 32'h1;
    for (int b = 8; b >= 0; b--) if (e[b]) return code_of_bit[b];
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_bad(input bit ip, input logic [8:0] e,
                                          input logic [31:0] pc,
                                          input logic [31:0] addr);
    if (ip) return 32'h0;
    for (int b = 8; b >= 0; b--) begin
      if (e[b]) begin
        if (b == 8) return pc;
        if (b == 2 || b == 1) return addr;
        return 32'h0;
      end
    end
    return 32'h0;
  endfunction

  task automatic clear_inputs();
    rst = 0; stall_i = 0; mem_valid_i = 0; mem_pc_i = 0;
    mem_in_delayslot_i = 0; mem_exc_i = 0; mem_addr_i = 0;
    cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
    wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_data_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clear_inputs();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1; mem_valid_i = 1; mem_exc_i = 9'h010;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (excepttype_o !== 32'h0) begin errors++; $display("FAIL reset_code got %h want 0", excepttype_o); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush_o); end
    checks++; if (new_pc_o !== 32'h0) begin errors++; $display("FAIL reset_newpc got %h want 0", new_pc_o); end
    checks++; if (bad_addr_o !== 32'h0) begin errors++; $display("FAIL reset_bad got %h want 0", bad_addr_o); end
    idle(1);
  endtask

  task automatic test_syscall();
    @(negedge clk);
    mem_valid_i = 1; mem_pc_i = 32'h80001000; mem_in_delayslot_i = 0; mem_exc_i = 9'h010;
    #1;
    checks++; if (excepttype_o !== 32'h8) begin errors++; $display("FAIL sys_code got %h want 8", excepttype_o); end
    checks++; if (current_inst_addr_o !== 32'h80001000) begin errors++; $display("FAIL sys_pc got %h want 80001000", current_inst_addr_o); end
    checks++; if (is_in_delayslot_o !== 1'b0) begin errors++; $display("FAIL sys_ds got %b want 0", is_in_delayslot_o); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL sys_early_flush got %b want 0", flush_o); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL sys_flush got %b want 1", flush_o); end
    checks++; if (new_pc_o !== VEC) begin errors++; $display("FAIL sys_newpc got %h want %h", new_pc_o, VEC); end
    @(negedge clk); #1;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL sys_flush_end got %b want 0", flush_o); end
    checks++; if (new_pc_o !== 32'h0) begin errors++; $display("FAIL sys_newpc_end got %h want 0", new_pc_o); end
    idle(1);
  endtask

  task automatic test_priority();
    logic [8:0]  pe [6] = '{9'h0D0, 9'h104, 9'h004, 9'h002, 9'h028, 9'h009};
    logic [31:0] pp [6] = '{32'h80000100, 32'h80000002, 32'h80000200, 32'h80000300, 32'h80000400, 32'h80000500};
    logic [31:0] pa [6] = '{32'h0, 32'h80000010, 32'h80000003, 32'h80000001, 32'h0, 32'h0};
    logic [31:0] pc_ [6] = '{32'hA, 32'h4, 32'h4, 32'h5, 32'hD, 32'h9};
    logic [31:0] pb [6] = '{32'h0, 32'h80000002, 32'h80000003, 32'h80000001, 32'h0, 32'h0};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mem_valid_i = 1; mem_pc_i = pp[k]; mem_addr_i = pa[k]; mem_exc_i = pe[k];
      mem_in_delayslot_i = k[0];
      #1;
      checks++; if (excepttype_o !== pc_[k]) begin errors++; $display("FAIL prio%0d_code got %h want %h", k, excepttype_o, pc_[k]); end
      checks++; if (bad_addr_o !== pb[k]) begin errors++; $display("FAIL prio%0d_bad got %h want %h", k, bad_addr_o, pb[k]); end
      checks++; if (is_in_delayslot_o !== k[0]) begin errors++; $display("FAIL prio%0d_ds got %b want %b", k, is_in_delayslot_o, k[0]); end
      idle(2);
    end
  endtask

  task automatic test_interrupt();
    @(negedge clk); cp0_status_i = 32'h00000401; cp0_cause_i = 0;
    @(negedge clk); cp0_cause_i = 32'h00000400; mem_valid_i = 1; #1;
    checks++; if (excepttype_o !== 32'h0) begin errors++; $display("FAIL int_early got %h want 0", excepttype_o); end
    @(negedge clk); #1;
    checks++; if (excepttype_o !== 32'h1) begin errors++; $display("FAIL int_code got %h want 1", excepttype_o); end
    @(negedge clk); mem_valid_i = 0; cp0_cause_i = 0; #1;
    checks++; if (flush_o !== 1'b1 || new_pc_o !== VEC) begin errors++; $display("FAIL int_flush got %b/%h want 1/%h", flush_o, new_pc_o, VEC); end
    idle(2);
    @(negedge clk); cp0_status_i = 32'h00000403; cp0_cause_i = 32'h00000400; mem_valid_i = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (excepttype_o !== 32'h0) begin errors++; $display("FAIL int_exl%0d got %h want 0", k, excepttype_o); end
      @(negedge clk);
    end
    idle(2);
  endtask

  task automatic test_eret_bypass();
    @(negedge clk);
    cp0_epc_i = 0; wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h80002000;
    mem_valid_i = 1; mem_pc_i = 32'h80000800; mem_exc_i = 9'h001;
    #1;
    checks++; if (excepttype_o !== 32'hE) begin errors++; $display("FAIL eret_code got %h want e", excepttype_o); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h80002000) begin errors++; $display("FAIL eret_newpc got %b/%h want 1/80002000", flush_o, new_pc_o); end
    idle(2);
  endtask

  task automatic test_stall();
    @(negedge clk); mem_valid_i = 1; mem_pc_i = 32'h80003000; mem_exc_i = 9'h010; stall_i = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (excepttype_o !== 32'h0) begin errors++; $display("FAIL stall%0d got %h want 0", k, excepttype_o); end
      @(negedge clk);
    end
    stall_i = 0; #1;
    checks++; if (excepttype_o !== 32'h8) begin errors++; $display("FAIL unstall_code got %h want 8", excepttype_o); end
    // A new sys arrives while flushing: must be ignored
    @(negedge clk); mem_pc_i = 32'h80003004; #1;
    checks++; if (excepttype_o !== 32'h0 || flush_o !== 1'b1) begin errors++; $display("FAIL flush_ignore got %h/%b want 0/1", excepttype_o, flush_o); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL flush_once got %b want 0", flush_o); end
    // Stall held across the flush cycle: still a single pulse
    @(negedge clk); mem_valid_i = 1; mem_exc_i = 9'h010; #1;
    checks++; if (excepttype_o !== 32'h8) begin errors++; $display("FAIL sys2_code got %h want 8", excepttype_o); end
    @(negedge clk); stall_i = 1; #1;
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL stall_flush got %b want 1", flush_o); end
    @(negedge clk); #1;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL stall_flush_once got %b want 0", flush_o); end
    idle(2);
  endtask

  task automatic test_reset_in_flush();
    @(negedge clk); mem_valid_i = 1; mem_exc_i = 9'h010; mem_pc_i = 32'h80004000;
    @(negedge clk); clear_inputs(); rst = 1;
    @(negedge clk); rst = 0; mem_valid_i = 1; mem_exc_i = 9'h040; mem_pc_i = 32'h80004010; #1;
    checks++; if (flush_o !== 1'b0 || new_pc_o !== 32'h0) begin errors++; $display("FAIL rstflush_out got %b/%h want 0/0", flush_o, new_pc_o); end
    checks++; if (excepttype_o !== 32'hC) begin errors++; $display("FAIL rstflush_run got %h want c", excepttype_o); end
    idle(2);
  endtask

  task automatic test_random();
    bit          m_flush = 0;
    bit          m_ip = 0;
    logic [31:0] m_target = 0;
    logic [31:0] s_eff, c_eff, e_eff, exp_code, exp_bad, exp_pc;
    bit          tk, nip;
    @(negedge clk); clear_inputs(); rst = 1;
    @(negedge clk);
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      stall_i = ($urandom_range(0, 4) == 0);
      mem_valid_i = ($urandom_range(0, 9) < 7);
      mem_pc_i = $urandom; mem_addr_i = $urandom;
      mem_in_delayslot_i = 1'($urandom_range(0, 1));
      for (int b = 0; b < 9; b++) mem_exc_i[b] = ($urandom_range(0, 11) == 0);
      cp0_status_i = $urandom;
      cp0_cause_i = $urandom & (($urandom_range(0, 2) == 0) ? 32'hFFFFFFFF : 32'hFFFF00FF);
      cp0_epc_i = $urandom;
      wb_cp0_we_i = ($urandom_range(0, 2) == 0);
      wb_cp0_waddr_i = 5'($urandom_range(11, 15));
      wb_cp0_data_i = $urandom;
      #1;
      s_eff = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_data_i : cp0_status_i;
      c_eff = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13)
              ? {cp0_cause_i[31:10], wb_cp0_data_i[9:8], cp0_cause_i[7:0]} : cp0_cause_i;
      e_eff = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_data_i : cp0_epc_i;
      nip = (|(s_eff[15:8] & c_eff[15:8])) && s_eff[0] && !s_eff[1];
      tk = !m_flush && mem_valid_i && !stall_i && !rst;
      exp_code = tk ? ref_code(m_ip, mem_exc_i) : 32'h0;
      exp_bad = tk ? ref_bad(m_ip, mem_exc_i, mem_pc_i, mem_addr_i) : 32'h0;
      exp_pc = m_flush ? m_target : 32'h0;
      checks++; if (excepttype_o !== exp_code) begin errors++; $display("FAIL rnd%0d_code got %h want %h", i, excepttype_o, exp_code); end
      checks++; if (bad_addr_o !== exp_bad) begin errors++; $display("FAIL rnd%0d_bad got %h want %h", i, bad_addr_o, exp_bad); end
      checks++; if (flush_o !== m_flush) begin errors++; $display("FAIL rnd%0d_flush got %b want %b", i, flush_o, m_flush); end
      checks++; if (new_pc_o !== exp_pc) begin errors++; $display("FAIL rnd%0d_newpc got %h want %h", i, new_pc_o, exp_pc); end
      checks++; if (current_inst_addr_o !== mem_pc_i) begin errors++; $display("FAIL rnd%0d_pc got %h want %h", i, current_inst_addr_o, mem_pc_i); end
      if (rst) begin
        m_flush = 0; m_ip = 0; m_target = 0;
      end else begin
        m_ip = nip;
        if (m_flush) m_flush = 0;
        else if (exp_code != 0) begin
          m_flush = 1;
          m_target = (exp_code == 32'hE) ? e_eff : VEC;
        end
      end
      @(negedge clk);
    end
    clear_inputs();
    idle(2);
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_priority();
    test_interrupt();
    test_eret_bypass();
    test_stall();
    test_reset_in_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- Exception/interrupt controller for the MEM stage.
- Merges the per-instruction exception flags and pending hardware/software interrupts into one prioritised `excepttype` code per cycle for cp0.
- Sequences the pipeline flush and the PC redirect to the exception vector or EPC.
- Bypasses in-flight WB-stage `mtc0` writes, so decisions always use up-to-date Status/Cause/EPC.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry PC.
- CP0_STATUS_ADDR, 5'd12, Status register number.
- CP0_CAUSE_ADDR, 5'd13, Cause register number.
- CP0_EPC_ADDR, 5'd14, EPC register number.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  MEM stage stalled; no commit this cycle.
- mem_valid_i  in  1  MEM holds a real instruction, not a bubble.
- mem_pc_i  in  32  PC of MEM instruction.
- mem_in_delayslot_i  in  1  MEM instruction is in a delay slot.
- mem_exc_i  in  9  flags {adel_if, ri, ovf, trap, sys, brk, adel_ls, ades, eret}.
- mem_addr_i  in  32  load/store effective address.
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current cp0 values.
- wb_cp0_we_i  in  1  WB-stage mtc0 write enable.
- wb_cp0_waddr_i  in  5  WB-stage mtc0 register number.
- wb_cp0_data_i  in  32  WB-stage mtc0 write data.
- excepttype_o  out  32  exception code to cp0; 0 = none.
- current_inst_addr_o  out  32  PC of the excepting instruction.
- is_in_delayslot_o  out  1  delay-slot flag for cp0.
- bad_addr_o  out  32  BadVAddr value for cp0.
- flush_o  out  1  flush all stages, one-cycle pulse.
- new_pc_o  out  32  redirect target; valid while flush_o=1.

Behaviour:
- Reset: all outputs 0, FSM=RUN, int_pend_q=0.
- Bypass: status_eff / cause_eff / epc_eff equal wb_cp0_data_i when wb_cp0_we_i and waddr matches, else the cp0 input.
  - Cause bypass replaces only bits [9:8] (software interrupts); all other Cause bits come from cp0_cause_i.
- Interrupt request: int_req = |(status_eff[15:8] & cause_eff[15:8]) & status_eff[0] & ~status_eff[1].
  - Registered each cycle into int_pend_q (1-cycle latency); int_pend_q is not sticky.
- Commit condition: take = (FSM==RUN) & mem_valid_i & ~stall_i. When take=0, excepttype_o=0.
- Priority when take=1, highest first:
  - int_pend_q → 32'h1.
  - adel_if → 32'h4; bad_addr = mem_pc_i.
  - ri → 32'hA.
  - ovf → 32'hC.
  - trap → 32'hD.
  - sys → 32'h8.
  - brk → 32'h9.
  - adel_ls → 32'h4; bad_addr = mem_addr_i.
  - ades → 32'h5; bad_addr = mem_addr_i.
  - eret → 32'hE.
  - Otherwise 0.
- excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o are combinational (same cycle). current_inst_addr_o = mem_pc_i; cp0 applies the delay-slot −4 adjustment. bad_addr_o = 0 when no address exception.
- FSM:
  - RUN→FLUSH when excepttype_o≠0.
  - FLUSH→RUN unconditionally after one cycle.
  - In FLUSH: flush_o=1; new_pc_o = registered target (EXC_VECTOR, or epc_eff sampled in the ERET cycle); excepttype_o forced to 0 even if mem_valid_i.
  - In RUN: flush_o=0, new_pc_o=0.
- ERET target uses epc_eff, so an mtc0 EPC in WB during the same cycle wins.
- Back-to-back: an exception is impossible in the FLUSH cycle; the next one is accepted only in the cycle after.
- stall_i during FLUSH: flush still pulses exactly once.
- rst in any state: next cycle RUN with all outputs 0; a pending redirect is discarded.

Decomposition:
- Shared package / defines hold the EXC_* codes (INT=1, ADEL=4, ADES=5, SYS=8, BP=9, RI=A, OVF=C, TR=D, ERET=E), CP0 register numbers, Status IE/EXL bit positions, and the FSM state enum {RUN, FLUSH}.
- One sub-module, `cp0_bypass`: combinational mtc0 forwarding of Status/Cause/EPC. The priority encoder and FSM stay in `except_ctrl`.

Test Plan:
- Syscall: sys at pc 0x80001000, delayslot=0 → excepttype 0x8, current_inst_addr 0x80001000; next cycle flush_o=1, new_pc_o=0xBFC00380; cycle after, flush_o=0.
- Priority: ri+ovf+sys set together → 0xA. adel_if (pc 0x80000002) + adel_ls → 0x4 with bad_addr 0x80000002. Alone, adel_ls with addr 0x80000003 → bad_addr 0x80000003.
- Interrupt: status=0x00000401, cause[10] rises at T → int_pend_q at T+1; valid instr at T+1 → excepttype 0x1. Repeat with status=0x00000403 (EXL=1) → no exception.
- ERET bypass: cp0_epc=0, WB mtc0 EPC=0x80002000 same cycle as eret → next cycle new_pc_o=0x80002000.
- Stall: sys with stall_i=1 for 3 cycles → excepttype 0 throughout; first unstalled cycle → 0x8. sys arriving during the FLUSH cycle → ignored.
- Reset: rst=1 in the FLUSH cycle → next cycle flush_o=0, excepttype_o=0, FSM=RUN.
